// File: rtl/knight_scanner_pkg.sv
// -----------------------------------------------------------------------------
// knight_pkg
// Shared constants and helpers for the Knight-Rider LED scanner.
//   MODE_*      : encodings of the 2-bit mode input
//   dir_e       : head direction, which is also the scanner FSM state
//   tail_level  : brightness of tail entry k (0-based) = FULL >> (k+1)
// -----------------------------------------------------------------------------
package knight_pkg;

  localparam logic [1:0] MODE_BOUNCE  = 2'd0;
  localparam logic [1:0] MODE_WRAP_UP = 2'd1;
  localparam logic [1:0] MODE_WRAP_DN = 2'd2;
  localparam logic [1:0] MODE_HOLD    = 2'd3;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int unsigned tail_level(input int unsigned k,
                                             input int unsigned pwm_bits);
    return ((32'd1 << pwm_bits) - 32'd1) >> (k + 32'd1);
  endfunction

endpackage

// File: rtl/knight_scanner_if.sv
// -----------------------------------------------------------------------------
// knight_scanner_if
// Control/status bundle of the scanner.
//   enable, mode, step_div : controls, driven by the master, sampled every clk
//   led                    : registered LED drive
//   pos, dir               : current head index and direction
//   step_pulse             : one-cycle qualifier, high in the cycle pos/dir/tail
//                            first show their new values
//   dbg_state              : FSM state (direction) for checkers
// There is no valid/ready pair: controls are level signals that take effect
// from the next rising edge, and step_pulse is a pure strobe that cannot be
// back-pressured.
// -----------------------------------------------------------------------------
interface knight_scanner_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
);
  import knight_pkg::*;

  localparam int POS_W = $clog2(WIDTH);

  logic                 enable;
  logic [1:0]           mode;
  logic [DIV_WIDTH-1:0] step_div;
  logic [WIDTH-1:0]     led;
  logic [POS_W-1:0]     pos;
  logic                 dir;
  logic                 step_pulse;
  dir_e                 dbg_state;

  modport master (
    output enable, mode, step_div,
    input  led, pos, dir, step_pulse, dbg_state
  );

  modport slave (
    input  enable, mode, step_div,
    output led, pos, dir, step_pulse, dbg_state
  );

endinterface

// File: rtl/knight_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// knight_pwm_dimmer
// Free-running PWM counter plus one comparator per LED; the LED outputs are
// registered so they change exactly one cycle after the brightness bus.
//   clk_in    : clock
//   reset     : synchronous active-high reset (counter and LEDs to 0)
//   i_bright  : WIDTH brightness levels, PWM_BITS each, LED i at [i*PWM_BITS +:]
//   o_led     : led[i] = (pwm_cnt < bright[i]), registered
// -----------------------------------------------------------------------------
module knight_pwm_dimmer #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [WIDTH*PWM_BITS-1:0] i_bright,
  output logic [WIDTH-1:0]          o_led
);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [WIDTH-1:0]    r_led;

  // Full brightness (all ones) is on for 2^PWM_BITS-1 of 2^PWM_BITS counts;
  // level 0 never lights.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      for (int i = 0; i < WIDTH; i++) begin
        r_led[i] <= (r_pwm_cnt < i_bright[i*PWM_BITS +: PWM_BITS]);
      end
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/knight_scanner.sv
// -----------------------------------------------------------------------------
// knight_scanner
// Knight-Rider LED scanner: a head LED steps across WIDTH LEDs once every
// step_div clocks, followed by TAIL fading positions rendered with PWM.
//   clk_in : system clock, rising edge
//   reset  : synchronous active-high reset, wins over everything
//   bus    : knight_scanner_if.slave (enable/mode/step_div in; led/pos/dir/
//            step_pulse/dbg_state out)
// Holds the prescaler, the position/direction FSM, the tail shift register and
// the per-LED brightness merge; PWM and the LED register live in
// knight_pwm_dimmer.
// -----------------------------------------------------------------------------
module knight_scanner
  import knight_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TAIL      = 3,
  parameter int PWM_BITS  = 4,
  parameter int DIV_WIDTH = 24
) (
  input  logic             clk_in,
  input  logic             reset,
  knight_scanner_if.slave  bus
);

  localparam int                  POS_W = $clog2(WIDTH);
  localparam logic [POS_W-1:0]    LAST  = POS_W'(WIDTH - 1);
  localparam logic [PWM_BITS-1:0] FULL  = '1;

  // ---------------------------------------------------------------------------
  // Prescaler. Compare with >= so that lowering step_div below the running
  // count ticks on the next cycle instead of waiting for a counter wrap.
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_div_m1;
  logic                 w_tick;

  assign w_div_m1 = (bus.step_div == '0) ? '0 : (bus.step_div - DIV_WIDTH'(1));
  assign w_tick   = bus.enable && (r_cnt >= w_div_m1);

  always_ff @(posedge clk_in) begin
    if (reset || !bus.enable || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Position/direction FSM: the direction is the state, pos is its datapath.
  // ---------------------------------------------------------------------------
  dir_e             r_dir;
  dir_e             w_dir_nxt;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] w_pos_nxt;
  logic             r_step_pulse;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_dir        <= DIR_UP;
      r_pos        <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_dir        <= w_dir_nxt;
      r_pos        <= w_pos_nxt;
      r_step_pulse <= w_tick;
    end
  end

  always_comb begin
    w_dir_nxt = r_dir;
    w_pos_nxt = r_pos;
    if (w_tick) begin
      case (bus.mode)
        MODE_BOUNCE: begin
          // Reverse on the end LED itself: no dwell, the next step already
          // moves one place back.
          if (r_dir == DIR_UP && r_pos == LAST) begin
            w_dir_nxt = DIR_DOWN;
            w_pos_nxt = LAST - POS_W'(1);
          end else if (r_dir == DIR_DOWN && r_pos == '0) begin
            w_dir_nxt = DIR_UP;
            w_pos_nxt = POS_W'(1);
          end else if (r_dir == DIR_UP) begin
            w_pos_nxt = r_pos + POS_W'(1);
          end else begin
            w_pos_nxt = r_pos - POS_W'(1);
          end
        end
        MODE_WRAP_UP: begin
          w_dir_nxt = DIR_UP;
          w_pos_nxt = (r_pos == LAST) ? '0 : (r_pos + POS_W'(1));
        end
        MODE_WRAP_DN: begin
          w_dir_nxt = DIR_DOWN;
          w_pos_nxt = (r_pos == '0) ? LAST : (r_pos - POS_W'(1));
        end
        default: begin
          // hold: pos and dir stay; the tail still shifts below
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tail shift register and brightness merge. Disabled operation forces every
  // level to 0, which blanks the LEDs one cycle later through the dimmer.
  // ---------------------------------------------------------------------------
  logic [WIDTH*PWM_BITS-1:0] w_bright;

  if (TAIL > 0) begin : g_tail
    logic [TAIL-1:0]  r_tail_vld;
    logic [POS_W-1:0] r_tail_idx [TAIL];
    logic [PWM_BITS-1:0] w_lvl;

    always_ff @(posedge clk_in) begin
      if (reset) begin
        r_tail_vld <= '0;
        for (int k = 0; k < TAIL; k++) begin
          r_tail_idx[k] <= '0;
        end
      end else if (w_tick) begin
        r_tail_vld[0] <= 1'b1;
        r_tail_idx[0] <= r_pos;
        for (int k = 1; k < TAIL; k++) begin
          r_tail_vld[k] <= r_tail_vld[k-1];
          r_tail_idx[k] <= r_tail_idx[k-1];
        end
      end
    end

    // Overlapping entries (bounce reversal, hold) resolve by max level; the
    // head always wins at FULL.
    always_comb begin
      w_bright = '0;
      w_lvl    = '0;
      for (int i = 0; i < WIDTH; i++) begin
        w_lvl = '0;
        for (int k = 0; k < TAIL; k++) begin
          if (r_tail_vld[k] && r_tail_idx[k] == POS_W'(i) &&
              PWM_BITS'(tail_level(k, PWM_BITS)) > w_lvl) begin
            w_lvl = PWM_BITS'(tail_level(k, PWM_BITS));
          end
        end
        if (r_pos == POS_W'(i)) begin
          w_lvl = FULL;
        end
        if (!bus.enable) begin
          w_lvl = '0;
        end
        w_bright[i*PWM_BITS +: PWM_BITS] = w_lvl;
      end
    end
  end else begin : g_no_tail
    always_comb begin
      w_bright = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.enable && r_pos == POS_W'(i)) begin
          w_bright[i*PWM_BITS +: PWM_BITS] = FULL;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM dimmer and outputs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_led;

  knight_pwm_dimmer #(
    .WIDTH    (WIDTH),
    .PWM_BITS (PWM_BITS)
  ) u_dimmer (
    .clk_in   (clk_in),
    .reset    (reset),
    .i_bright (w_bright),
    .o_led    (w_led)
  );

  assign bus.led        = w_led;
  assign bus.pos        = r_pos;
  assign bus.dir        = r_dir;
  assign bus.step_pulse = r_step_pulse;
  assign bus.dbg_state  = r_dir;

endmodule

// File: tb/tb_knight_scanner.sv
// -----------------------------------------------------------------------------
// tb_knight_scanner
// Two scanners driven by the same controls: A (TAIL=0, PWM_BITS=1) and
// B (TAIL=2, PWM_BITS=4). A reference model built from position history and
// brightness arithmetic predicts every output each cycle; directed steps add
// explicit checks for the scenarios of interest, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_knight_scanner;
  import knight_pkg::*;

  localparam int W      = 8;
  localparam int DW     = 24;
  localparam int TAIL_A = 0;
  localparam int PWM_A  = 1;
  localparam int TAIL_B = 2;
  localparam int PWM_B  = 4;

  // clock / reset
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  // stimulus
  logic          t_enable   = 1'b1;
  logic [1:0]    t_mode     = 2'd0;
  logic [DW-1:0] t_step_div = '0;

  knight_scanner_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus_a ();
  knight_scanner_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus_b ();

  assign bus_a.enable   = t_enable;
  assign bus_a.mode     = t_mode;
  assign bus_a.step_div = t_step_div;
  assign bus_b.enable   = t_enable;
  assign bus_b.mode     = t_mode;
  assign bus_b.step_div = t_step_div;

  knight_scanner #(.WIDTH(W), .TAIL(TAIL_A), .PWM_BITS(PWM_A), .DIV_WIDTH(DW))
    u_dut_a (.clk_in(clk_in), .reset(reset), .bus(bus_a));
  knight_scanner #(.WIDTH(W), .TAIL(TAIL_B), .PWM_BITS(PWM_B), .DIV_WIDTH(DW))
    u_dut_b (.clk_in(clk_in), .reset(reset), .bus(bus_b));

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_pos   = 0;
  int         m_dir   = 1;
  int         m_cnt   = 0;
  int         m_pulse = 0;
  int         m_pwm [2] = '{0, 0};
  int         hist_q[$];            // past head positions, most recent first
  logic [W-1:0] exp_led [2] = '{'0, '0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    hist_q.push_front(m_pos);
    if (hist_q.size() > W) void'(hist_q.pop_back());
    case (t_mode)
      2'd0: begin
        if (m_dir == 1 && m_pos == W - 1) begin
          m_dir = 0; m_pos = W - 2;
        end else if (m_dir == 0 && m_pos == 0) begin
          m_dir = 1; m_pos = 1;
        end else begin
          m_pos = m_pos + ((m_dir == 1) ? 1 : -1);
        end
      end
      2'd1: begin m_dir = 1; m_pos = (m_pos + 1) % W; end
      2'd2: begin m_dir = 0; m_pos = (m_pos + W - 1) % W; end
      default: ;
    endcase
  endtask

  // Advance the model by one rising edge using the inputs present at the edge.
  task automatic model_edge();
    int full, b, d, p, t;
    if (reset) begin
      m_pos = 0; m_dir = 1; m_cnt = 0; m_pulse = 0;
      hist_q.delete();
      m_pwm[0] = 0; m_pwm[1] = 0;
      exp_led[0] = '0; exp_led[1] = '0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      p    = (c == 0) ? PWM_A : PWM_B;
      t    = (c == 0) ? TAIL_A : TAIL_B;
      full = (1 << p) - 1;
      for (int i = 0; i < W; i++) begin
        b = 0;
        for (int k = 0; k < t && k < hist_q.size(); k++) begin
          if (hist_q[k] == i && (full >> (k + 1)) > b) b = full >> (k + 1);
        end
        if (m_pos == i) b = full;
        exp_led[c][i] = t_enable && (m_pwm[c] < b);
      end
      m_pwm[c] = (m_pwm[c] + 1) % (1 << p);
    end
    d = (t_step_div == '0) ? 1 : int'(t_step_div);
    m_pulse = 0;
    if (!t_enable) begin
      m_cnt = 0;
    end else if (m_cnt >= d - 1) begin
      m_cnt = 0;
      m_pulse = 1;
      model_step();
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("led_a",   bus_a.led,        exp_led[0]);
    chk("led_b",   bus_b.led,        exp_led[1]);
    chk("pos_a",   bus_a.pos,        m_pos);
    chk("pos_b",   bus_b.pos,        m_pos);
    chk("dir_a",   bus_a.dir,        m_dir);
    chk("dir_b",   bus_b.dir,        m_dir);
    chk("pulse_a", bus_a.step_pulse, m_pulse);
    chk("pulse_b", bus_b.step_pulse, m_pulse);
  endtask

  // driver: one clock edge, model update, then sample 1 ns after the edge
  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_pulse(input int target, input int budget, input string tag);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      tick();
      if (bus_a.step_pulse === 1'b1 && (target < 0 || int'(bus_a.pos) == target))
        found = 1'b1;
    end
    chk({tag, "_timeout"}, {31'd0, found}, 32'd1);
  endtask

  int on_cnt [W];
  logic [W-1:0] led_or;
  int exp_p;

  initial begin
    // 1. reset held 3 cycles with enable=1, step_div=5
    reset = 1'b1; t_enable = 1'b1; t_step_div = DW'(5); t_mode = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_led", bus_b.led, 0);
      chk("rst_pos", bus_a.pos, 0);
      chk("rst_dir", bus_a.dir, 1);
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("first_pulse", bus_a.step_pulse, (k == 5) ? 1 : 0);
      chk("first_pos",   bus_a.pos,        (k == 5) ? 1 : 0);
    end

    // 2. bounce with a step every cycle
    reset = 1'b1; tick(); reset = 1'b0;
    t_step_div = DW'(1); t_mode = 2'd0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_p = (k <= 7) ? k : ((k <= 14) ? 14 - k : k - 14);
      chk("bounce_pos", bus_a.pos, exp_p);
      chk("bounce_dir", bus_a.dir, (k >= 8 && k <= 14) ? 0 : 1);
    end

    // 3. wrap up, then wrap down
    t_mode = 2'd1; t_step_div = DW'(2);
    wait_pulse(6, 40, "wrap6");
    tick(); tick(); chk("wrap_pos7", bus_a.pos, 7);
    tick(); tick(); chk("wrap_pos0", bus_a.pos, 0);
    tick(); tick(); chk("wrap_pos1", bus_a.pos, 1);
    t_mode = 2'd2;
    tick(); tick(); chk("wrapdn_pos0", bus_a.pos, 0); chk("wrapdn_dir", bus_a.dir, 0);
    tick(); tick(); chk("wrapdn_pos7", bus_a.pos, 7);

    // 4. tail dimming duty with head at 5
    t_mode = 2'd1; t_step_div = DW'(64);
    wait_pulse(5, 1000, "tail5");
    for (int i = 0; i < W; i++) on_cnt[i] = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      for (int i = 0; i < W; i++) on_cnt[i] += int'(bus_b.led[i]);
    end
    for (int i = 0; i < W; i++) begin
      chk("tail_duty", on_cnt[i], (i == 5) ? 15 : (i == 4) ? 7 : (i == 3) ? 3 : 0);
    end

    // 5. enable drop mid-interval, re-enable, then hold
    t_step_div = DW'(4);
    wait_pulse(3, 200, "en3");
    tick();
    t_enable = 1'b0;
    tick();
    chk("dis_led_a", bus_a.led, 0);
    chk("dis_led_b", bus_b.led, 0);
    chk("dis_pos", bus_a.pos, 3);
    tick(); tick(); tick();
    chk("dis_hold_pos", bus_a.pos, 3);
    t_enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("reen_pulse", bus_a.step_pulse, (k == 4) ? 1 : 0);
    end
    t_mode = 2'd3;
    for (int n = 0; n < 12; n++) tick();
    led_or = '0;
    for (int n = 0; n < 16; n++) begin
      tick();
      led_or |= bus_b.led;
    end
    chk("hold_led", led_or, 32'h10);
    chk("hold_pos", bus_b.pos, 4);

    // 6. step_div corner cases and mid-run reset
    t_mode = 2'd1; t_step_div = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("div0_pulse", bus_a.step_pulse, 1);
    end
    t_step_div = DW'(10);
    wait_pulse(-1, 30, "div10");
    for (int k = 0; k < 7; k++) tick();
    t_step_div = DW'(2);
    tick(); chk("div_drop_p1", bus_a.step_pulse, 1);
    tick(); chk("div_drop_p2", bus_a.step_pulse, 0);
    tick(); chk("div_drop_p3", bus_a.step_pulse, 1);
    reset = 1'b1;
    tick();
    chk("midrst_led_a", bus_a.led, 0);
    chk("midrst_led_b", bus_b.led, 0);
    chk("midrst_pos", bus_b.pos, 0);
    chk("midrst_dir", bus_b.dir, 1);
    chk("midrst_pulse", bus_b.step_pulse, 0);
    reset = 1'b0;

    // 7. randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 7) == 0)  t_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) t_step_div = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) t_enable = ~t_enable;
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knight_scanner.md
Name: knight_scanner

Overview:
Parametrised Knight-Rider LED scanner with a PWM-dimmed fading tail.
- A single lit "head" moves across WIDTH LEDs once per programmable step interval.
- The TAIL most recent head positions glow at successively halved brightness.
- Mode input selects bounce, wrap-left, wrap-right or hold.
- Sits directly in front of the board LED pins; driven from the system clock, with no external divider.

Parameters:
WIDTH, 8, number of LEDs (legal range 2..64)
TAIL, 3, number of fading tail positions (legal range 0..PWM_BITS)
PWM_BITS, 4, PWM counter width; full brightness = 2^PWM_BITS-1
DIV_WIDTH, 24, width of step_div

Ports:
clk_in  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  run/stop
mode  input  2  0=bounce, 1=wrap-left (up), 2=wrap-right (down), 3=hold
step_div  input  DIV_WIDTH  clk_in cycles per head step; 0 is treated as 1
led  output  WIDTH  registered LED drive, 1=on
pos  output  $clog2(WIDTH)  current head index
dir  output  1  current direction, 1=up (towards MSB)
step_pulse  output  1  one-cycle pulse in the cycle pos updates

Behaviour:
- Reset values (reset sampled high at a clk_in edge):
  - pos=0, dir=1, led=0, step_pulse=0.
  - Prescaler=0, PWM counter=0, all tail valid bits=0.
  - Reset has priority over every other input, including mid-step.
- Prescaler:
  - Counts 0..D-1, where D=max(step_div,1); tick when count==D-1, then count returns to 0.
  - step_div is sampled every cycle. If step_div is lowered below the current count, tick on the next cycle, then restart from 0.
- Step (on tick with enable=1):
  - mode 0 (bounce):
    - dir=1 and pos==WIDTH-1 -> dir<=0, pos<=WIDTH-2.
    - dir=0 and pos==0 -> dir<=1, pos<=1.
    - Otherwise pos moves one place in direction dir.
    - No dwell at the ends.
  - mode 1: dir<=1, pos<=pos+1; wraps WIDTH-1 -> 0.
  - mode 2: dir<=0, pos<=pos-1; wraps 0 -> WIDTH-1.
  - mode 3: pos and dir hold. Tail still shifts so it collapses onto the head.
  - Mode changes take effect at the next tick. dir is forced as listed; pos is never jumped.
  - step_pulse is registered: high for exactly one cycle, the same cycle pos/dir/tail show their new values.
- Tail:
  - Shift register of TAIL entries, each holding {valid, index}.
  - On each step, entry0<=old pos (valid=1) and entry k<=entry k-1.
  - Entry k (0-based) has brightness FULL>>(k+1), where FULL=2^PWM_BITS-1.
- Brightness per LED i:
  - FULL if pos==i, else the max brightness of any valid tail entry with index==i, else 0.
  - Overlap (after a bounce reversal, or in hold) resolves by max.
- PWM:
  - Free-running PWM_BITS counter, reset to 0, runs regardless of enable.
  - led[i] <= (pwm_cnt < bright[i]), registered.
  - Exactly one cycle latency from a pos/tail change to led.
  - Head duty is FULL/2^PWM_BITS.
- enable=0:
  - Prescaler is cleared and held.
  - pos, dir and tail hold.
  - led<=0 from the next cycle; step_pulse=0.
- enable 0->1: first step occurs D cycles later.
- After reset release with enable=1: first step_pulse occurs on cycle D (cycle 1 = first cycle after reset low).
- TAIL=0: no tail logic; only the head is lit, at FULL duty.

Decomposition:
- Package knight_pkg:
  - Mode constants MODE_BOUNCE=0, MODE_WRAP_UP=1, MODE_WRAP_DN=2, MODE_HOLD=3.
  - Function tail_level(k, PWM_BITS) returning FULL>>(k+1).
- One sub-module, knight_pwm_dimmer:
  - Parameters WIDTH and PWM_BITS.
  - Owns the PWM counter and the per-LED comparators plus the led register.
  - Takes a flattened WIDTH*PWM_BITS brightness bus.
- knight_scanner keeps the prescaler, the position/direction FSM, the tail shift register and the brightness merge.

Test Plan:
1. Reset: WIDTH=8, hold reset 3 cycles with enable=1, step_div=5 -> during and right after reset led=0, pos=0, dir=1; first step_pulse on cycle 5 after release, pos=1.
2. Bounce: step_div=1, mode=0, TAIL=0, PWM_BITS=1 -> pos sequence 1,2..7,6..0,1; dir flips in the cycles pos becomes 6 and 1; led shows a one-hot on pos each PWM-on cycle.
3. Wrap: mode=1, step_div=2 -> pos 6,7,0,1 with a step every 2 cycles, dir=1; switch to mode=2 at pos=1 -> next step pos=0, then 7, dir=0.
4. Tail dimming: TAIL=2, PWM_BITS=4, mode=1, step_div=64, measure over 16 cycles between steps with head at 5 -> led[5] on 15/16 cycles, led[4] on 7/16, led[3] on 3/16, all other LEDs 0/16.
5. Enable/hold: deassert enable mid-interval at pos=3 -> led=0 the next cycle, pos stays 3; reassert -> step after exactly D cycles. Mode=3 -> pos frozen; after TAIL steps only the head LED is lit.
6. step_div edge cases: step_div=0 -> a step every cycle; change step_div 10 -> 2 while the prescaler is at 7 -> tick next cycle, then every 2 cycles; assert reset mid-run -> all outputs return to their reset values on the next edge.
